// File: rtl/rng_digit_stream_pkg.sv
// rng_digit_stream_pkg: shared widths, FSM encodings and the index-width helper
package rng_digit_stream_pkg;
  localparam int DIGIT_DEF = 32;
  localparam int BLK_W = 96;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rng_digit_stream_if.sv
// rng_digit_stream_if: word stream handshake plus the prng request/response bus
interface rng_digit_stream_if
  import rng_digit_stream_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEF
);
  logic [DIGIT-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             prng_in_ready;
  logic [BLK_W-1:0] prng_seed;
  logic             prng_mod;
  logic [BLK_W-1:0] prng_rng;
  logic             prng_out_ready;
  modport master (
    output word_out, word_valid, prng_in_ready, prng_seed, prng_mod,
    input  word_ready, prng_rng, prng_out_ready
  );
  modport slave (
    input  word_out, word_valid, prng_in_ready, prng_seed, prng_mod,
    output word_ready, prng_rng, prng_out_ready
  );
endinterface

// File: rtl/rng_digit_stream.sv
// rng_digit_stream: requests prng blocks with chained reseeding and streams them as DIGIT-bit words
module rng_digit_stream
  import rng_digit_stream_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [BLK_W-1:0] seed_in,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  rng_digit_stream_if.master io
);
  localparam int NW = BLK_W / DIGIT;
  localparam int IDX_W = idx_width(NW);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NW - 1);

  logic [2:0]       state_q, state_d;
  logic [BLK_W-1:0] seed_q, seed_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      sa;
  logic [BLK_W-1:0] sh;
  logic             hs;

  // next-state logic: sequencing, chained reseed and word accounting
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    blk_d    = blk_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    hs       = io.word_ready;
    case (state_q)
      S_IDLE: if (start) begin
        seed_d   = seed_in;
        remain_d = num_words;
        state_d  = num_words == '0 ? S_FIN : S_REQ;
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: if (io.prng_out_ready) begin
        blk_d   = io.prng_rng;
        seed_d  = io.prng_rng;
        idx_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: if (hs) begin
        remain_d = remain_q - CNT_W'(1);
        idx_d    = idx_q + IDX_W'(1);
        state_d  = remain_q == CNT_W'(1) ? S_FIN : idx_q == LAST ? S_REQ : S_DRAIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, cleared asynchronously so a mid-job reset drops the job
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      seed_q   <= '0;
      blk_q    <= '0;
      remain_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      blk_q    <= blk_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
    end
  end

  // most significant word first: shift the selected word up to the top of the block
  always_comb begin
    sa = 32'(idx_q) * 32'(DIGIT);
    sh = blk_q << sa;
  end

  assign io.word_out      = sh[BLK_W-1 -: DIGIT];
  assign io.word_valid    = state_q == S_DRAIN;
  assign io.prng_in_ready = state_q == S_REQ;
  assign io.prng_seed     = seed_q;
  assign io.prng_mod      = 1'b1;
  assign busy             = state_q != S_IDLE;
  assign done             = state_q == S_FIN;
endmodule
